apb_master: RTL and testbench

- APB requester that drives the parking-lift register slave (and any other APB3-style completer in the design) from a simple valid/ready command port.
- The host side (lift controller FSM or bench driver) issues one read or write per command and receives one response per command.
- Generates the SETUP/ACCESS phases, waits on PREADY with a timeout, and captures read data.
- Supports completers that register PRDATA one cycle after the ACCESS phase.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_master.sv | 110 +++++++++++
 tb/tb_apb_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding, default bus widths and
// the parking-lift register map used by the lift controller and benches.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } apb_state_t;

  localparam int APB_ADDRESSWIDTH = 4;
  localparam int APB_DATAWIDTH    = 16;

  localparam logic [3:0] COMMAND_TX  = 4'd1;
  localparam logic [3:0] TRANSMIT_TX = 4'd2;
  localparam logic [3:0] ID_TX       = 4'd3;
  localparam logic [3:0] DATA_TX     = 4'd4;
  localparam logic [3:0] RECEIVE_RX  = 4'd5;
  localparam logic [3:0] ID_RX       = 4'd6;
  localparam logic [3:0] DATA_RX     = 4'd7;
  localparam logic [3:0] STATUS      = 4'd8;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: turns one valid/ready command into a SETUP/ACCESS transfer
// and returns one response, aborting with an error if PREADY never arrives.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDRESSWIDTH   = APB_ADDRESSWIDTH,
  parameter int DATAWIDTH      = APB_DATAWIDTH,
  parameter int RDATA_LATE     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr_i,
  input  logic [DATAWIDTH-1:0]    cmd_wdata_i,
  output logic                    rsp_valid_o,
  output logic [DATAWIDTH-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDRESSWIDTH-1:0] PADDR_o,
  output logic [DATAWIDTH-1:0]    PWDATA_o,
  output logic                    PWRITE_o,
  output logic                    PSELx_o,
  output logic                    PENABLE_o,
  input  logic [DATAWIDTH-1:0]    PRDATA_i,
  input  logic                    PREADY_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  apb_state_t    state;
  logic [TW-1:0] tcnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      tcnt        <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      PADDR_o     <= '0;
      PWDATA_o    <= '0;
      PWRITE_o    <= 1'b0;
      PSELx_o     <= 1'b0;
      PENABLE_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            PADDR_o     <= cmd_addr_i;
            PWDATA_o    <= cmd_wdata_i;
            PWRITE_o    <= cmd_write_i;
            PSELx_o     <= 1'b1;
            cmd_ready_o <= 1'b0;
            tcnt        <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          PENABLE_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (PREADY_i) begin
            PSELx_o   <= 1'b0;
            PENABLE_o <= 1'b0;
            if (PWRITE_o || (RDATA_LATE == 0)) begin
              state       <= IDLE;
              cmd_ready_o <= 1'b1;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= PWRITE_o ? '0 : PRDATA_i;
            end else begin
              // Registered-read completer: data only appears one edge later.
              state <= CAPTURE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
              PSELx_o     <= 1'b0;
              PENABLE_o   <= 1'b0;
              state       <= IDLE;
              cmd_ready_o <= 1'b1;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end
          end
        end
        CAPTURE: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= PRDATA_i;
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          PSELx_o     <= 1'b0;
          PENABLE_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a registered-read completer model.
module tb_apb_master;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_write;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [3:0]  paddr;
  logic [15:0] pwdata;
  logic        pwrite, psel, penable;
  logic [15:0] prdata = 16'h0000;
  logic        pready;
  logic [15:0] rd_val;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master #(
    .ADDRESSWIDTH(4), .DATAWIDTH(16), .RDATA_LATE(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .PADDR_o(paddr), .PWDATA_o(pwdata), .PWRITE_o(pwrite),
    .PSELx_o(psel), .PENABLE_o(penable),
    .PRDATA_i(prdata), .PREADY_i(pready)
  );

  always #5 PCLK = ~PCLK;

  // Completer registers read data on the completing ACCESS edge; otherwise junk.
  always @(posedge PCLK)
    prdata <= (psel && penable && pready && !pwrite) ? rd_val : 16'hDEAD;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Presents one command for a single cycle; returns in the SETUP cycle.
  task automatic issue(input logic w, input logic [3:0] a, input logic [15:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    check_val("issue_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit seen, bad;
    int en, nrsp;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; pready = 1'b1; rd_val = 16'h0000;
    repeat (2) @(posedge PCLK);
    #1;
    check_val("rst_ready",   32'(cmd_ready), 1);
    check_val("rst_psel",    32'(psel), 0);
    check_val("rst_penable", 32'(penable), 0);
    check_val("rst_rspv",    32'(rsp_valid), 0);
    check_val("rst_paddr",   32'(paddr), 0);
    check_val("rst_rdata",   32'(rsp_rdata), 0);
    check_val("rst_err",     32'(rsp_err), 0);
    PRESETn = 1'b1;
    tick();

    // Write, zero wait states
    issue(1'b1, ID_TX, 16'h00A5);
    check_val("w_setup_psel",   32'(psel), 1);
    check_val("w_setup_pen",    32'(penable), 0);
    check_val("w_setup_paddr",  32'(paddr), 3);
    check_val("w_setup_pwdata", 32'(pwdata), 16'h00A5);
    check_val("w_setup_pwrite", 32'(pwrite), 1);
    check_val("w_setup_ready",  32'(cmd_ready), 0);
    tick();
    check_val("w_acc_pen",   32'(penable), 1);
    check_val("w_acc_psel",  32'(psel), 1);
    check_val("w_acc_rspv",  32'(rsp_valid), 0);
    tick();
    check_val("w_rsp_valid", 32'(rsp_valid), 1);
    check_val("w_rsp_err",   32'(rsp_err), 0);
    check_val("w_rsp_rdata", 32'(rsp_rdata), 0);
    check_val("w_rsp_psel",  32'(psel), 0);
    check_val("w_rsp_ready", 32'(cmd_ready), 1);
    tick();
    check_val("w_rsp_pulse", 32'(rsp_valid), 0);

    // Read with late PRDATA
    rd_val = 16'h0042;
    issue(1'b0, ID_RX, 16'h0000);
    check_val("r_setup_pwrite", 32'(pwrite), 0);
    check_val("r_setup_paddr",  32'(paddr), 6);
    tick();
    check_val("r_acc_pen", 32'(penable), 1);
    tick();
    check_val("r_cap_psel",  32'(psel), 0);
    check_val("r_cap_pen",   32'(penable), 0);
    check_val("r_cap_rspv",  32'(rsp_valid), 0);
    check_val("r_cap_ready", 32'(cmd_ready), 0);
    tick();
    check_val("r_rsp_valid", 32'(rsp_valid), 1);
    check_val("r_rsp_rdata", 32'(rsp_rdata), 16'h0042);
    check_val("r_rsp_err",   32'(rsp_err), 0);
    tick();
    check_val("r_rsp_pulse", 32'(rsp_valid), 0);
    check_val("r_rdata_hold", 32'(rsp_rdata), 16'h0042);

    // PREADY stuck low: abort after 16 ACCESS cycles
    pready = 1'b0;
    issue(1'b0, DATA_RX, 16'h0000);
    seen = 0; en = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (penable) en++;
      if (rsp_valid) seen = 1; else tick();
    end
    check_val("to_seen",  32'(seen), 1);
    check_val("to_cycles", 32'(en), 16);
    check_val("to_err",   32'(rsp_err), 1);
    check_val("to_rdata", 32'(rsp_rdata), 0);
    check_val("to_psel",  32'(psel), 0);
    check_val("to_pen",   32'(penable), 0);
    check_val("to_ready", 32'(cmd_ready), 1);
    tick();
    check_val("to_err_hold", 32'(rsp_err), 1);

    // Write with 3 wait states
    issue(1'b1, DATA_TX, 16'h1234);
    seen = 0; en = 0; bad = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (psel && (paddr !== DATA_TX || pwdata !== 16'h1234 || pwrite !== 1'b1)) bad = 1;
      if (penable) begin
        en++;
        if (en == 4) pready = 1'b1;
      end
      if (rsp_valid) seen = 1; else tick();
    end
    check_val("ws_seen",   32'(seen), 1);
    check_val("ws_pen_cycles", 32'(en), 4);
    check_val("ws_stable", 32'(bad), 0);
    check_val("ws_err",    32'(rsp_err), 0);
    tick();
    check_val("ws_single", 32'(rsp_valid), 0);

    // Back-to-back writes with cmd_valid held
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = COMMAND_TX; cmd_wdata = 16'h1111;
    tick();
    cmd_addr = TRANSMIT_TX; cmd_wdata = 16'h2222;
    tick();
    check_val("bb_c2_paddr", 32'(paddr), 1);
    check_val("bb_c2_pen",   32'(penable), 1);
    tick();
    check_val("bb_c3_rspv",  32'(rsp_valid), 1);
    check_val("bb_c3_psel",  32'(psel), 0);
    check_val("bb_c3_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check_val("bb_c4_psel",   32'(psel), 1);
    check_val("bb_c4_pen",    32'(penable), 0);
    check_val("bb_c4_paddr",  32'(paddr), 2);
    check_val("bb_c4_pwdata", 32'(pwdata), 16'h2222);
    tick();
    tick();
    check_val("bb_c6_rspv", 32'(rsp_valid), 1);
    tick();
    check_val("bb_c7_rspv", 32'(rsp_valid), 0);
    check_val("bb_c7_psel", 32'(psel), 0);

    // Reset during ACCESS
    pready = 1'b0;
    issue(1'b1, RECEIVE_RX, 16'h5A5A);
    tick();
    check_val("rs_in_access", 32'(penable), 1);
    #2 PRESETn = 1'b0;
    #1;
    check_val("rs_psel", 32'(psel), 0);
    check_val("rs_pen",  32'(penable), 0);
    check_val("rs_rspv", 32'(rsp_valid), 0);
    tick();
    PRESETn = 1'b1;
    pready = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || psel) nrsp++;
      tick();
    end
    check_val("rs_no_rsp", 32'(nrsp), 0);
    check_val("rs_ready",  32'(cmd_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
